// File: rtl/pc_exception_seq.sv
// Exception/return sequencer ahead of the PC-source mux: saves EPC, fetches the
// handler pointer byte, then owns pc_src_sel/pc_write for one PC load.
module pc_exception_seq #(
  parameter logic [7:0]  VEC_OPCODE = 8'd253,
  parameter logic [7:0]  VEC_OVF    = 8'd254,
  parameter logic [7:0]  VEC_DIV0   = 8'd255,
  parameter int          MEM_LAT    = 1,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic        rte_req,
  input  logic [31:0] pc_in,
  input  logic [7:0]  mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic [31:0] exception_destiny,
  output logic [1:0]  pc_src_sel,
  output logic        pc_write,
  output logic        override,
  output logic        busy,
  output logic [1:0]  cause
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SAVE  = 3'd1,
    MREQ  = 3'd2,
    MWAIT = 3'd3,
    LOAD  = 3'd4,
    RTE   = 3'd5
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] mem_addr_q;
  logic        mem_rd_q;
  logic        epc_wr_q;
  logic [31:0] epc_data_q;
  logic [31:0] destiny_q;
  logic [1:0]  pc_src_sel_q;
  logic        pc_write_q;
  logic        override_q;
  logic        busy_q;
  logic [1:0]  cause_q;

  logic        exc_any;
  logic [1:0]  cause_d;
  logic [7:0]  vec_d;
  logic [31:0] epc_d;

  assign exc_any = exc_opcode | exc_ovf | exc_div0;
  assign epc_d   = pc_in - EPC_OFFSET;

  // Fixed priority: opcode > overflow > div0.
  always_comb begin
    cause_d = 2'b11;
    vec_d   = VEC_DIV0;
    if (exc_opcode) begin
      cause_d = 2'b01;
      vec_d   = VEC_OPCODE;
    end else if (exc_ovf) begin
      cause_d = 2'b10;
      vec_d   = VEC_OVF;
    end
  end

  // Outputs are loaded on the edge entering each state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      mem_addr_q   <= 32'd0;
      mem_rd_q     <= 1'b0;
      epc_wr_q     <= 1'b0;
      epc_data_q   <= 32'd0;
      destiny_q    <= 32'd0;
      pc_src_sel_q <= 2'b00;
      pc_write_q   <= 1'b0;
      override_q   <= 1'b0;
      busy_q       <= 1'b0;
      cause_q      <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (exc_any) begin
            state_q    <= SAVE;
            cause_q    <= cause_d;
            mem_addr_q <= {24'd0, vec_d};
            epc_wr_q   <= 1'b1;
            epc_data_q <= epc_d;
            busy_q     <= 1'b1;
          end else if (rte_req) begin
            state_q      <= RTE;
            cause_q      <= 2'b00;
            override_q   <= 1'b1;
            pc_src_sel_q <= 2'b01;
            pc_write_q   <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        SAVE: begin
          state_q  <= MREQ;
          epc_wr_q <= 1'b0;
          mem_rd_q <= 1'b1;
        end
        MREQ: begin
          state_q  <= MWAIT;
          mem_rd_q <= 1'b0;
          cnt_q    <= LAT_M1;
        end
        MWAIT: begin
          if (cnt_q == 2'd0) begin
            state_q      <= LOAD;
            destiny_q    <= {24'd0, mem_data_in};
            override_q   <= 1'b1;
            pc_src_sel_q <= 2'b00;
            pc_write_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        LOAD, RTE: begin
          state_q    <= IDLE;
          override_q <= 1'b0;
          pc_write_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          mem_rd_q   <= 1'b0;
          epc_wr_q   <= 1'b0;
          override_q <= 1'b0;
          pc_write_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr          = mem_addr_q;
  assign mem_rd            = mem_rd_q;
  assign epc_wr            = epc_wr_q;
  assign epc_data          = epc_data_q;
  assign exception_destiny = destiny_q;
  assign pc_src_sel        = pc_src_sel_q;
  assign pc_write          = pc_write_q;
  assign override          = override_q;
  assign busy              = busy_q;
  assign cause             = cause_q;

endmodule

// File: tb/tb_pc_exception_seq.sv
// Directed bench: u1 runs with MEM_LAT=1, u3 with MEM_LAT=3 on the same stimulus.
module tb_pc_exception_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exc_opcode = 1'b0, exc_ovf = 1'b0, exc_div0 = 1'b0, rte_req = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic [7:0]  mem_data_in = 8'd0;

  logic [31:0] a1_mem_addr, a1_epc_data, a1_dest;
  logic        a1_mem_rd, a1_epc_wr, a1_pc_write, a1_override, a1_busy;
  logic [1:0]  a1_sel, a1_cause;
  logic [31:0] a3_mem_addr, a3_epc_data, a3_dest;
  logic        a3_mem_rd, a3_epc_wr, a3_pc_write, a3_override, a3_busy;
  logic [1:0]  a3_sel, a3_cause;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_exception_seq #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
    .exc_div0(exc_div0), .rte_req(rte_req), .pc_in(pc_in), .mem_data_in(mem_data_in),
    .mem_addr(a1_mem_addr), .mem_rd(a1_mem_rd), .epc_wr(a1_epc_wr), .epc_data(a1_epc_data),
    .exception_destiny(a1_dest), .pc_src_sel(a1_sel), .pc_write(a1_pc_write),
    .override(a1_override), .busy(a1_busy), .cause(a1_cause)
  );

  pc_exception_seq #(.MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
    .exc_div0(exc_div0), .rte_req(rte_req), .pc_in(pc_in), .mem_data_in(mem_data_in),
    .mem_addr(a3_mem_addr), .mem_rd(a3_mem_rd), .epc_wr(a3_epc_wr), .epc_data(a3_epc_data),
    .exception_destiny(a3_dest), .pc_src_sel(a3_sel), .pc_write(a3_pc_write),
    .override(a3_override), .busy(a3_busy), .cause(a3_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {busy, override, pc_write, mem_rd, epc_wr, cause, pc_src_sel}
  function automatic logic [31:0] strobes1();
    return {23'd0, a1_busy, a1_override, a1_pc_write, a1_mem_rd, a1_epc_wr, a1_cause, a1_sel};
  endfunction

  initial begin
    // Reset held for two cycles.
    step();
    step();
    chk("rst_strobes", strobes1(), 32'd0);
    chk("rst_addr", a1_mem_addr, 32'd0);
    chk("rst_dest", a1_dest, 32'd0);
    chk("rst_epc", a1_epc_data, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_strobes", strobes1(), 32'd0);
    end

    // Overflow, MEM_LAT=1.
    exc_ovf = 1'b1; pc_in = 32'h0000_0040; mem_data_in = 8'h7C;
    step();  // cycle 0: SAVE
    exc_ovf = 1'b0;
    chk("ovf_c0_epc_wr", {31'd0, a1_epc_wr}, 32'd1);
    chk("ovf_c0_epc_data", a1_epc_data, 32'h0000_003C);
    chk("ovf_c0_busy", {31'd0, a1_busy}, 32'd1);
    chk("ovf_c0_override", {31'd0, a1_override}, 32'd0);
    chk("ovf_c0_cause", {30'd0, a1_cause}, 32'd2);
    step();  // cycle 1: MREQ
    chk("ovf_c1_mem_rd", {31'd0, a1_mem_rd}, 32'd1);
    chk("ovf_c1_mem_addr", a1_mem_addr, 32'd254);
    chk("ovf_c1_epc_wr", {31'd0, a1_epc_wr}, 32'd0);
    step();  // cycle 2: MWAIT
    chk("ovf_c2_mem_rd", {31'd0, a1_mem_rd}, 32'd0);
    chk("ovf_c2_pc_write", {31'd0, a1_pc_write}, 32'd0);
    chk("ovf_c2_mem_addr", a1_mem_addr, 32'd254);
    step();  // cycle 3: LOAD
    chk("ovf_c3_pc_write", {31'd0, a1_pc_write}, 32'd1);
    chk("ovf_c3_override", {31'd0, a1_override}, 32'd1);
    chk("ovf_c3_sel", {30'd0, a1_sel}, 32'd0);
    chk("ovf_c3_dest", a1_dest, 32'h0000_007C);
    step();  // back to IDLE
    chk("ovf_idle_busy", {31'd0, a1_busy}, 32'd0);
    chk("ovf_idle_pc_write", {31'd0, a1_pc_write}, 32'd0);
    chk("ovf_hold_dest", a1_dest, 32'h0000_007C);
    chk("ovf_hold_cause", {30'd0, a1_cause}, 32'd2);
    for (int i = 0; i < 4; i++) step();

    // Priority: all three exceptions at once.
    exc_opcode = 1'b1; exc_ovf = 1'b1; exc_div0 = 1'b1;
    pc_in = 32'h0000_0100; mem_data_in = 8'h11;
    step();
    exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
    chk("prio_cause", {30'd0, a1_cause}, 32'd1);
    chk("prio_epc", a1_epc_data, 32'h0000_00FC);
    step();
    chk("prio_mem_addr", a1_mem_addr, 32'd253);
    step();
    step();
    chk("prio_load_dest", a1_dest, 32'h0000_0011);
    chk("prio_load_pc_write", {31'd0, a1_pc_write}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("prio_single_seq", {31'd0, a1_busy}, 32'd0);
    end
    for (int i = 0; i < 2; i++) step();

    // Busy masking, then RTE.
    exc_ovf = 1'b1; mem_data_in = 8'h22;
    step();  // SAVE
    exc_ovf = 1'b0;
    step();  // MREQ
    step();  // MWAIT
    exc_div0 = 1'b1;
    step();  // LOAD
    exc_div0 = 1'b0;
    chk("mask_cause", {30'd0, a1_cause}, 32'd2);
    chk("mask_dest", a1_dest, 32'h0000_0022);
    step();  // IDLE
    chk("mask_idle_busy", {31'd0, a1_busy}, 32'd0);
    rte_req = 1'b1;
    step();  // RTE
    rte_req = 1'b0;
    chk("rte_sel", {30'd0, a1_sel}, 32'd1);
    chk("rte_pc_write", {31'd0, a1_pc_write}, 32'd1);
    chk("rte_override", {31'd0, a1_override}, 32'd1);
    chk("rte_cause", {30'd0, a1_cause}, 32'd0);
    chk("rte_epc_wr", {31'd0, a1_epc_wr}, 32'd0);
    step();
    chk("rte_done", {31'd0, a1_busy | a1_override | a1_pc_write}, 32'd0);
    chk("rte_dest_hold", a1_dest, 32'h0000_0022);
    for (int i = 0; i < 6; i++) step();

    // Wrap and latency on the MEM_LAT=3 instance, with rte_req colliding.
    exc_div0 = 1'b1; rte_req = 1'b1; pc_in = 32'h0000_0002; mem_data_in = 8'h5A;
    step();  // cycle 0
    exc_div0 = 1'b0; rte_req = 1'b0;
    chk("wrap_epc_wr", {31'd0, a3_epc_wr}, 32'd1);
    chk("wrap_epc_data", a3_epc_data, 32'hFFFF_FFFE);
    chk("wrap_cause", {30'd0, a3_cause}, 32'd3);
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("lat3_pc_write_c%0d", c), {31'd0, a3_pc_write}, (c == 5) ? 32'd1 : 32'd0);
      if (c == 1) begin
        chk("lat3_mem_rd", {31'd0, a3_mem_rd}, 32'd1);
        chk("lat3_mem_addr", a3_mem_addr, 32'd255);
      end
      if (c == 5) begin
        chk("lat3_dest", a3_dest, 32'h0000_005A);
        chk("lat3_sel", {30'd0, a3_sel}, 32'd0);
      end
    end
    chk("collide_cause", {30'd0, a3_cause}, 32'd3);
    step();
    chk("collide_no_rte", {31'd0, a3_busy | a3_pc_write}, 32'd0);
    for (int i = 0; i < 2; i++) step();

    // Reset during MWAIT, then a clean opcode sequence.
    exc_ovf = 1'b1; pc_in = 32'h0000_0080; mem_data_in = 8'h33;
    step();
    exc_ovf = 1'b0;
    step();
    step();  // MWAIT
    chk("mid_busy", {31'd0, a1_busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_strobes", strobes1(), 32'd0);
    chk("mid_rst_addr", a1_mem_addr, 32'd0);
    chk("mid_rst_dest", a1_dest, 32'd0);
    step();
    chk("mid_rst_hold", strobes1(), 32'd0);
    reset = 1'b1;
    step();
    exc_opcode = 1'b1; pc_in = 32'h0000_0200; mem_data_in = 8'h44;
    step();
    exc_opcode = 1'b0;
    chk("post_epc", a1_epc_data, 32'h0000_01FC);
    chk("post_cause", {30'd0, a1_cause}, 32'd1);
    step();
    chk("post_mem_addr", a1_mem_addr, 32'd253);
    chk("post_mem_rd", {31'd0, a1_mem_rd}, 32'd1);
    step();
    step();
    chk("post_pc_write", {31'd0, a1_pc_write}, 32'd1);
    chk("post_dest", a1_dest, 32'h0000_0044);
    step();
    chk("post_idle", {31'd0, a1_busy | a1_pc_write}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_exception_seq.md
Name: pc_exception_seq

Overview:
- Exception/return sequencer directly upstream of the PC-source mux and the PC register.
- On an invalid-opcode, overflow or divide-by-zero event it:
  - saves EPC;
  - fetches the 8-bit handler address byte from memory;
  - presents it as Exception_Destiny;
  - steers the mux (select 00) and pulses PC write.
- On a return-from-exception request it steers select 01 (EPC_Out) and pulses PC write.
- While sequencing, it overrides the main control unit's PC-source select and PC write.

Parameters:
- VEC_OPCODE, 253, byte address of the invalid-opcode handler pointer.
- VEC_OVF, 254, byte address of the overflow handler pointer.
- VEC_DIV0, 255, byte address of the divide-by-zero handler pointer.
- MEM_LAT, 1, cycles from mem_rd to valid mem_data_in; legal range 1..4.
- EPC_OFFSET, 4, value subtracted from pc_in to form EPC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- exc_opcode  in  1  invalid-opcode event, sampled in IDLE.
- exc_ovf  in  1  ALU overflow event, sampled in IDLE.
- exc_div0  in  1  divide-by-zero event, sampled in IDLE.
- rte_req  in  1  return-from-exception request, sampled in IDLE.
- pc_in  in  32  current PC register value.
- mem_data_in  in  8  byte read from memory.
- mem_addr  out  32  memory byte address.
- mem_rd  out  1  memory read strobe.
- epc_wr  out  1  EPC register write enable.
- epc_data  out  32  value to write into EPC.
- exception_destiny  out  32  zero-extended handler address; feeds mux input 00.
- pc_src_sel  out  2  mux select, valid while override=1.
- pc_write  out  1  PC register write enable, valid while override=1.
- override  out  1  sequencer owns pc_src_sel and pc_write this cycle.
- busy  out  1  high in every state except IDLE.
- cause  out  2  last exception: 00 none, 01 opcode, 10 overflow, 11 div0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0.
  - All 1-bit outputs 0; mem_addr=0, epc_data=0, exception_destiny=0, cause=00, pc_src_sel=00.
- All outputs are registered; each value below is visible in the cycle the machine is in the named state.
- IDLE:
  - override=0, busy=0.
  - Any exc_* high at a clock edge moves to SAVE.
  - Priority: exc_opcode > exc_ovf > exc_div0. The winner is latched into cause, and its vector into mem_addr.
  - Otherwise, rte_req high moves to RTE.
  - If an exception and rte_req are high together, the exception wins and rte_req is dropped.
- SAVE (1 cycle):
  - epc_wr=1, epc_data = pc_in(latched at the edge leaving IDLE) - EPC_OFFSET, mod 2^32.
  - At pc_in < EPC_OFFSET the result wraps; no saturation.
  - Next state: MREQ.
- MREQ (1 cycle):
  - mem_rd=1, mem_addr = selected vector, zero-extended to 32 bits.
  - Wait counter loads MEM_LAT-1.
  - Next state: MWAIT.
- MWAIT:
  - mem_rd=0; mem_addr holds.
  - Counter decrements each cycle; at counter=0, mem_data_in is captured into exception_destiny[7:0] and bits [31:8] are set to 0.
  - Next state: LOAD.
  - With MEM_LAT=1 this state lasts exactly one cycle.
- LOAD (1 cycle):
  - override=1, pc_src_sel=00, pc_write=1.
  - Next state: IDLE.
- RTE (1 cycle):
  - override=1, pc_src_sel=01, pc_write=1, cause cleared to 00.
  - Next state: IDLE.
- Latency with MEM_LAT=1: the exception edge into SAVE is cycle 0; pc_write is asserted in cycle 3. In general pc_write is asserted in cycle 2+MEM_LAT.
- busy:
  - exc_* and rte_req are ignored while busy=1. No queuing, no nesting.
  - A request held high across the return to IDLE is taken again at that edge.
- exception_destiny and cause hold their values after LOAD until the next capture, RTE, or reset.
- Reset asserted mid-sequence (any state) aborts immediately:
  - All strobes deassert asynchronously.
  - No partial PC write is ever produced.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> all outputs 0, busy=0, override=0 for 10 idle cycles.
- Overflow, MEM_LAT=1:
  - Stimulus: exc_ovf pulse with pc_in=0x00000040; mem_data_in=0x7C returned one cycle after mem_rd.
  - Required: epc_wr=1 with epc_data=0x0000003C at cycle 0; mem_rd=1 with mem_addr=254 at cycle 1; pc_write=1, pc_src_sel=00, exception_destiny=0x0000007C at cycle 3; cause=10.
- Priority: exc_opcode, exc_ovf, exc_div0 all high in the same cycle -> mem_addr=253, cause=01; only one sequence runs.
- Busy masking: exc_div0 pulsed during MWAIT, then rte_req pulsed in the cycle after LOAD -> div0 ignored; RTE gives pc_src_sel=01, pc_write=1, cause=00.
- Wrap and latency:
  - MEM_LAT=3, exc_div0 with pc_in=0x00000002 -> epc_data=0xFFFFFFFE; mem_addr=255; pc_write exactly 5 cycles after entering SAVE.
  - Exception and rte_req together -> exception sequence only.
- Reset mid-op: assert reset during MWAIT -> outputs 0 within the same cycle; after release a new exc_opcode runs a full, correct sequence.
